// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: valid/ready word in, one registered bit per clock out.
// Define SER_PARITY_EN to append one even-parity bit after each word.
module seq_bit_serializer #(
   parameter int DATA_W    = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              bit_out,
   output logic              bit_valid,
   output logic              word_done,
   output logic              busy
);

   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] LAST    = CW'(DATA_W - 1);
   localparam logic [CW-1:0] LAST_M1 = CW'(DATA_W - 2);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      PARITY
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              bo_d, bv_d, wd_d;
   logic              last_bit, final_cyc, accept;
   logic              first_bit, next_bit;
   logic [DATA_W-1:0] sh_shift;
`ifdef SER_PARITY_EN
   logic              par_q, par_d;
`endif

   assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);
`ifdef SER_PARITY_EN
   assign final_cyc = (state_q == PARITY);
`else
   assign final_cyc = last_bit;
`endif
   // in_ready never looks at in_valid
   assign in_ready = !reset && ((state_q == IDLE) || final_cyc);
   assign accept   = in_valid && in_ready;
   assign busy     = (state_q != IDLE);

   assign first_bit = (MSB_FIRST != 0) ? in_data[DATA_W-1] : in_data[0];
   assign next_bit  = (MSB_FIRST != 0) ? sh_q[DATA_W-2] : sh_q[1];
   assign sh_shift  = (MSB_FIRST != 0) ? {sh_q[DATA_W-2:0], 1'b0}
                                       : {1'b0, sh_q[DATA_W-1:1]};

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      bo_d    = 1'b0;
      bv_d    = 1'b0;
      wd_d    = 1'b0;
`ifdef SER_PARITY_EN
      par_d   = par_q;
`endif
      if (accept) begin
         state_d = SHIFT;
         sh_d    = in_data;
         cnt_d   = '0;
         bo_d    = first_bit;
         bv_d    = 1'b1;
`ifdef SER_PARITY_EN
         par_d   = ^in_data;
`endif
      end else if (last_bit) begin
         cnt_d = '0;
`ifdef SER_PARITY_EN
         state_d = PARITY;
         bo_d    = par_q;
         bv_d    = 1'b1;
         wd_d    = 1'b1;
`else
         state_d = IDLE;
`endif
      end else if (state_q == SHIFT) begin
         sh_d  = sh_shift;
         cnt_d = cnt_q + CW'(1);
         bo_d  = next_bit;
         bv_d  = 1'b1;
`ifndef SER_PARITY_EN
         wd_d  = (cnt_q == LAST_M1);
`endif
      end else begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         sh_q      <= '0;
         cnt_q     <= '0;
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
         word_done <= 1'b0;
`ifdef SER_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         sh_q      <= sh_d;
         cnt_q     <= cnt_d;
         bit_out   <= bo_d;
         bit_valid <= bv_d;
         word_done <= wd_d;
`ifdef SER_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed testbench for seq_bit_serializer (MSB-first and LSB-first instances).
// Honours SER_PARITY_EN when the design is built with it.
module tb_seq_bit_serializer;

`ifdef SER_PARITY_EN
   localparam int WL = 9;
`else
   localparam int WL = 8;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready, bit_out, bit_valid, word_done, busy;

   logic [7:0] l_data = 8'h00;
   logic       l_valid = 1'b0;
   logic       l_ready, l_bit, l_bv, l_wd, l_busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   seq_bit_serializer #(.DATA_W(8), .MSB_FIRST(1)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .bit_out(bit_out), .bit_valid(bit_valid),
      .word_done(word_done), .busy(busy)
   );

   seq_bit_serializer #(.DATA_W(8), .MSB_FIRST(0)) dut_l (
      .clk(clk), .reset(reset), .in_data(l_data), .in_valid(l_valid),
      .in_ready(l_ready), .bit_out(l_bit), .bit_valid(l_bv),
      .word_done(l_wd), .busy(l_busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // expected serial bit i of word w (index 8 is the parity bit)
   function automatic logic exp_msb(input logic [7:0] w, input int i);
      if (i < 8) return w[7-i];
      return ^w;
   endfunction

   function automatic logic exp_lsb(input logic [7:0] w, input int i);
      if (i < 8) return w[i];
      return ^w;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      n_cmp++;
      if ({bit_out, bit_valid, word_done, busy, in_ready} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_state got=%b want=00000",
                  {bit_out, bit_valid, word_done, busy, in_ready});
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_release_ready got=%b want=1", in_ready);
      end
   endtask

   task automatic test_single(input logic [7:0] w);
      logic eb;
      in_data  = w;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      in_data  = 8'h5A;
      for (int i = 0; i < WL; i++) begin
         eb = exp_msb(w, i);
         n_cmp++;
         if ({bit_valid, bit_out, word_done, in_ready} !==
             {1'b1, eb, i == WL-1, i == WL-1}) begin
            n_bad++;
            $display("FAIL single_%h_bit%0d got v/b/d/r=%b want=%b", w, i,
                     {bit_valid, bit_out, word_done, in_ready},
                     {1'b1, eb, i == WL-1, i == WL-1});
         end
         step();
      end
      n_cmp++;
      if ({bit_valid, bit_out, word_done, in_ready, busy} !== 5'b00010) begin
         n_bad++;
         $display("FAIL single_%h_idle got=%b want=00010", w,
                  {bit_valid, bit_out, word_done, in_ready, busy});
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] w;
      logic eb;
      int acc = 0;
      in_data  = 8'hA5;
      in_valid = 1'b1;
      acc++;
      step();
      in_data = 8'h3C;
      for (int c = 0; c < 2*WL; c++) begin
         w  = (c < WL) ? 8'hA5 : 8'h3C;
         eb = exp_msb(w, c % WL);
         n_cmp++;
         if ({bit_valid, bit_out, word_done, in_ready} !==
             {1'b1, eb, (c % WL) == WL-1, (c % WL) == WL-1}) begin
            n_bad++;
            $display("FAIL b2b_cyc%0d got v/b/d/r=%b want=%b", c + 1,
                     {bit_valid, bit_out, word_done, in_ready},
                     {1'b1, eb, (c % WL) == WL-1, (c % WL) == WL-1});
         end
         if (in_valid && in_ready) acc++;
         step();
         if (c == WL-1) in_valid = 1'b0;
      end
      n_cmp++;
      if (acc !== 2) begin
         n_bad++;
         $display("FAIL b2b_accepts got=%0d want=2", acc);
      end
      n_cmp++;
      if ({bit_valid, bit_out, busy} !== 3'b000) begin
         n_bad++;
         $display("FAIL b2b_idle got=%b want=000", {bit_valid, bit_out, busy});
      end
   endtask

   task automatic test_lsb();
      logic eb;
      l_data  = 8'h0D;
      l_valid = 1'b1;
      step();
      l_valid = 1'b0;
      for (int i = 0; i < WL; i++) begin
         eb = exp_lsb(8'h0D, i);
         n_cmp++;
         if ({l_bv, l_bit, l_wd} !== {1'b1, eb, i == WL-1}) begin
            n_bad++;
            $display("FAIL lsb_bit%0d got v/b/d=%b want=%b", i,
                     {l_bv, l_bit, l_wd}, {1'b1, eb, i == WL-1});
         end
         step();
      end
      n_cmp++;
      if ({l_bv, l_bit, l_ready} !== 3'b001) begin
         n_bad++;
         $display("FAIL lsb_idle got=%b want=001", {l_bv, l_bit, l_ready});
      end
   endtask

   task automatic test_mid_reset();
      int seen = 0;
      in_data  = 8'hFF;
      in_valid = 1'b1;
      step();
      step();
      step();
      reset = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_ready got=%b want=0", in_ready);
      end
      step();
      reset    = 1'b0;
      in_valid = 1'b0;
      n_cmp++;
      if ({bit_valid, bit_out, busy, word_done} !== 4'b0000) begin
         n_bad++;
         $display("FAIL rst_flush got=%b want=0000",
                  {bit_valid, bit_out, busy, word_done});
      end
      for (int i = 0; i < WL + 2; i++) begin
         if (bit_valid || word_done) seen++;
         step();
      end
      n_cmp++;
      if (seen !== 0) begin
         n_bad++;
         $display("FAIL rst_no_resend got=%0d want=0", seen);
      end
   endtask

   initial begin
      step();
      test_reset();
      test_single(8'hB0);
      test_back_to_back();
      test_lsb();
      test_mid_reset();
      test_single(8'h07);
      test_single(8'h81);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seq_bit_serializer.md
# seq_bit_serializer

Parallel-to-serial front end for the bit-serial pattern-detection path. It accepts DATA_W-bit words over a valid/ready handshake and emits them one bit per clock on a registered serial output. That output drives the `inp_bit` input of the downstream sequence detector. Back-to-back words stream with no gap, so patterns that straddle word boundaries stay detectable.

## Interface

Parameters:
- DATA_W, default 8: word width; legal range ≥ 2.
- MSB_FIRST, default 1: 1 = bit DATA_W-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  reset, synchronous, active-high.
- in_data  input  DATA_W  word to serialize; sampled on accept.
- in_valid  input  1  upstream has a word on in_data.
- in_ready  output  1  block can accept a word this cycle (combinational from state/counter only, never from in_valid).
- bit_out  output  1  serial data bit (registered); connects to detector inp_bit.
- bit_valid  output  1  bit_out carries a real data/parity bit (registered).
- word_done  output  1  one-cycle pulse while the final bit of a word is on bit_out (registered).
- busy  output  1  state ≠ IDLE.

## Operation

- Accept: a word is accepted on any rising edge where in_valid && in_ready && !reset.
- State machine:
  - IDLE: waits for accept; accept → SHIFT.
  - SHIFT: walks the data bits of the current word; after last data bit → PARITY (parity build) or IDLE / SHIFT again (see below).
  - PARITY: parity builds only; one cycle; → IDLE or SHIFT.
- in_ready:
  - 0 while reset is high.
  - 1 in IDLE.
  - 1 during the final serial cycle of a word: last data bit, or the parity cycle in parity builds.
  - 0 otherwise.
- Shift register:
  - Loaded with in_data on accept.
  - Bit counter width $clog2(DATA_W+1); counts 0..DATA_W-1 over data bits.
  - Bit order per MSB_FIRST.
- End of word:
  - Accept during the final cycle: load the new word; first bit appears next cycle; stay in SHIFT; no idle bubble.
  - No accept: → IDLE, bit_valid=0, bit_out=0.
- Idle fill: bit_out is forced to 0 whenever bit_valid=0.
- Reset:
  - Values: state IDLE, bit_out 0, bit_valid 0, word_done 0, busy 0, counter 0.
  - A word in flight is discarded with no partial completion.
  - Reset dominates a simultaneous accept.

## Timing

- Latency: a word accepted at edge N presents its first bit in the cycle after edge N. Bit k is presented after edge N+k.
- Word length: DATA_W cycles per word (DATA_W+1 with parity).
- Sustained throughput: one bit per clock while in_valid is held high.
- word_done aligns with the final bit of each word: last data bit, or the parity bit in parity builds.
- in_data may change freely after the accepting edge.

## Configuration

- SER_PARITY_EN defined:
  - Each word is followed by one even-parity bit, the XOR of all DATA_W data bits.
  - Parity cycle: bit_valid=1, word_done=1, in_ready=1.
  - in_ready is 0 on the last data bit.
- SER_PARITY_EN undefined:
  - No PARITY state; words are exactly DATA_W bits.
  - in_ready is 1 on the last data bit.

## Test plan

- Single word MSB first (DATA_W=8, MSB_FIRST=1), accept 0xB0 → bit_out 1,0,1,1,0,0,0,0 on cycles 1–8; bit_valid high cycles 1–8; word_done only cycle 8; then idle (bit_out 0, bit_valid 0, in_ready 1).
- Back-to-back 0xA5 then 0x3C with in_valid held → 16 contiguous valid bits 1010_0101_0011_1100; second accept on cycle 8; word_done on cycles 8 and 16; no gap.
- LSB first (MSB_FIRST=0), 0x0D → bit_out 1,0,1,1,0,0,0,0; the detector downstream asserts seq_seen after the 4th bit.
- Reset on cycle 3 of word 0xFF with in_valid high → next cycle bit_valid=0, bit_out=0, busy=0; no word_done; the word is not resent; a fresh accept works normally.
- Backpressure: in_valid high throughout mid-word → in_ready 0 on cycles 1–7 and 1 only on cycle 8; exactly one accept per word.
- SER_PARITY_EN, 0x07 → 0,0,0,0,0,1,1,1 then parity 1 on cycle 9; word_done cycle 9 only; in_ready 0 on cycle 8 and 1 on cycle 9.
